// File: rtl/debug_controller.sv
// UART-driven debug sequencer for the five-stage MIPS pipeline: loads instruction
// memory, runs or single-steps the core, then dumps PC, registers and a data window.
module debug_controller #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_ADDR     = 10,
  parameter int unsigned NB_REG      = 5,
  parameter int unsigned N_REGISTER  = 32,
  parameter int unsigned N_MEM_WORDS = 16,
  parameter int unsigned N_BYTES     = 4,
  parameter logic [NB_DATA-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_data_reg,
  input  logic [NB_DATA-1:0] i_data_mem,
  input  logic               i_halt,
  output logic [NB_DATA-1:0] o_im_data,
  output logic [NB_ADDR-1:0] o_im_addr,
  output logic               o_im_enable_write,
  output logic               o_en_read,
  output logic               o_debug_unit,
  output logic               o_enable_pipe,
  output logic [NB_REG-1:0]  o_br_addr,
  output logic               o_br_enable,
  output logic [NB_ADDR-1:0] o_dm_addr,
  output logic               o_dm_enable,
  output logic               o_dm_enable_addr,
  output logic               o_busy
);

  localparam int unsigned N_WORDS = 1 + N_REGISTER + N_MEM_WORDS;
  localparam int unsigned NB_IDX  = $clog2(N_WORDS);
  localparam int unsigned NB_BCNT = $clog2(N_BYTES);

  localparam logic [NB_IDX-1:0]  LAST_IDX  = NB_IDX'(N_WORDS - 1);
  localparam logic [NB_IDX-1:0]  REG_LAST  = NB_IDX'(N_REGISTER);
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(N_BYTES - 1);
  localparam logic [NB_ADDR-1:0] ADDR_MAX  = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STEP_IDLE,
    S_STEP_EXEC,
    S_DUMP_ADDR,
    S_DUMP_LATCH,
    S_DUMP_SEND,
    S_DUMP_WAIT
  } state_t;

  state_t               state;
  logic [NB_DATA-9:0]   shift;
  logic [NB_BCNT-1:0]   byte_cnt;
  logic [NB_ADDR-1:0]   load_addr;
  logic                 load_full;
  logic [NB_IDX-1:0]    word_idx;
  logic [NB_DATA-9:0]   dump_rest;
  logic                 step_mode;

  logic [NB_DATA-1:0]   load_word;
  logic [NB_DATA-1:0]   capture;
  logic                 dump_rd;
  logic                 is_reg;
  logic                 is_mem;

  assign load_word = {shift, i_rx_data};

  always_comb begin
    capture = i_data_mem;
    if (word_idx == '0) begin
      capture = NB_DATA'(i_pc);
    end else if (word_idx <= REG_LAST) begin
      capture = i_data_reg;
    end
  end

  // Debug read address and enable are held through ADDR and LATCH so either a
  // registered or a combinational read port sees a stable request.
  assign dump_rd          = (state == S_DUMP_ADDR) || (state == S_DUMP_LATCH);
  assign is_reg           = (word_idx != '0) && (word_idx <= REG_LAST);
  assign is_mem           = word_idx > REG_LAST;
  assign o_br_enable      = dump_rd && is_reg;
  assign o_br_addr        = o_br_enable ? NB_REG'(word_idx - 1'b1) : '0;
  assign o_dm_enable      = dump_rd && is_mem;
  assign o_dm_enable_addr = o_dm_enable;
  assign o_dm_addr        = o_dm_enable ? NB_ADDR'(word_idx - REG_LAST - 1'b1) : '0;

  assign o_debug_unit  = (state == S_LOAD);
  assign o_en_read     = (state == S_RUN) || (state == S_STEP_EXEC);
  assign o_enable_pipe = ((state == S_RUN) && !i_halt) || (state == S_STEP_EXEC);
  assign o_busy        = (state != S_IDLE) && (state != S_STEP_IDLE);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state             <= S_IDLE;
      shift             <= '0;
      byte_cnt          <= '0;
      load_addr         <= '0;
      load_full         <= 1'b0;
      word_idx          <= '0;
      dump_rest         <= '0;
      step_mode         <= 1'b0;
      o_im_data         <= '0;
      o_im_addr         <= '0;
      o_im_enable_write <= 1'b0;
      o_tx_data         <= '0;
      o_tx_start        <= 1'b0;
    end else begin
      o_im_enable_write <= 1'b0;
      o_tx_start        <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_rx_done) begin
            byte_cnt <= '0;
            if (i_rx_data == 8'h4C) state <= S_LOAD;
            else if (i_rx_data == 8'h43) state <= S_RUN;
            else if (i_rx_data == 8'h53) state <= S_STEP_IDLE;
          end
        end
        S_STEP_IDLE: begin
          if (i_rx_done) begin
            if (i_rx_data == 8'h4E) state <= S_STEP_EXEC;
            else if (i_rx_data == 8'h45) state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (i_rx_done) begin
            shift <= load_word[NB_DATA-9:0];
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              if (!load_full) begin
                o_im_enable_write <= 1'b1;
                o_im_data         <= load_word;
                o_im_addr         <= load_addr;
              end
              // The top location is written once; later words only wait for halt.
              if (load_word == HALT_INSTR) begin
                state     <= S_IDLE;
                load_addr <= '0;
                load_full <= 1'b0;
              end else if (!load_full) begin
                if (load_addr == ADDR_MAX) load_full <= 1'b1;
                else load_addr <= load_addr + 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (i_halt) begin
            step_mode <= 1'b0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            state     <= S_DUMP_ADDR;
          end
        end
        S_STEP_EXEC: begin
          step_mode <= 1'b1;
          word_idx  <= '0;
          byte_cnt  <= '0;
          state     <= S_DUMP_ADDR;
        end
        S_DUMP_ADDR: state <= S_DUMP_LATCH;
        S_DUMP_LATCH: begin
          dump_rest  <= capture[NB_DATA-9:0];
          o_tx_data  <= capture[NB_DATA-1 -: 8];
          o_tx_start <= 1'b1;
          state      <= S_DUMP_SEND;
        end
        S_DUMP_SEND: state <= S_DUMP_WAIT;
        S_DUMP_WAIT: begin
          if (i_tx_done) begin
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              if (word_idx == LAST_IDX) begin
                state <= (step_mode && !i_halt) ? S_STEP_IDLE : S_IDLE;
              end else begin
                word_idx <= word_idx + 1'b1;
                state    <= S_DUMP_ADDR;
              end
            end else begin
              byte_cnt   <= byte_cnt + 1'b1;
              o_tx_data  <= dump_rest[NB_DATA-9 -: 8];
              dump_rest  <= dump_rest << 8;
              o_tx_start <= 1'b1;
              state      <= S_DUMP_SEND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// Scoreboard bench for debug_controller: expected writes and dump bytes are queued
// when commands are sent and checked as the controller emits strobes and tx pulses.
module tb_debug_controller;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clock      = 1'b0;
  logic        i_reset    = 1'b1;
  logic [7:0]  i_rx_data  = '0;
  logic        i_rx_done  = 1'b0;
  logic        i_tx_done  = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic [9:0]  i_pc;
  logic [31:0] i_data_reg;
  logic [31:0] i_data_mem;
  logic        i_halt;
  logic [31:0] o_im_data;
  logic [9:0]  o_im_addr;
  logic        o_im_enable_write;
  logic        o_en_read;
  logic        o_debug_unit;
  logic        o_enable_pipe;
  logic [4:0]  o_br_addr;
  logic        o_br_enable;
  logic [9:0]  o_dm_addr;
  logic        o_dm_enable;
  logic        o_dm_enable_addr;
  logic        o_busy;

  always #5 clock = ~clock;

  debug_controller #(
    .NB_DATA(32), .NB_ADDR(10), .NB_REG(5), .N_REGISTER(32),
    .N_MEM_WORDS(16), .N_BYTES(4), .HALT_INSTR(32'hFFFF_FFFF)
  ) dut (
    .clock(clock), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_tx_done(i_tx_done),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .i_pc(i_pc), .i_data_reg(i_data_reg), .i_data_mem(i_data_mem), .i_halt(i_halt),
    .o_im_data(o_im_data), .o_im_addr(o_im_addr), .o_im_enable_write(o_im_enable_write),
    .o_en_read(o_en_read), .o_debug_unit(o_debug_unit), .o_enable_pipe(o_enable_pipe),
    .o_br_addr(o_br_addr), .o_br_enable(o_br_enable),
    .o_dm_addr(o_dm_addr), .o_dm_enable(o_dm_enable), .o_dm_enable_addr(o_dm_enable_addr),
    .o_busy(o_busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_val(input int unsigned r);
    logic [7:0] b;
    b = r[7:0];
    return (r == 0) ? 32'h0 : {b, 8'hA5, ~b, 8'h3C};
  endfunction

  function automatic logic [31:0] mem_val(input int unsigned m);
    return 32'hC0DE_0000 + 32'(m * 273);
  endfunction

  // Pipeline model: PC advances on each enabled edge; halt rises once the
  // armed number of enabled edges has elapsed.
  logic [9:0]  pipe_pc  = 10'd100;
  int unsigned pipe_cnt = 0;
  int unsigned halt_at  = 0;
  logic        halt_arm = 1'b0;
  logic [31:0] reg_q    = '0;
  logic [31:0] mem_q    = '0;

  assign i_pc       = pipe_pc;
  assign i_halt     = halt_arm && (pipe_cnt >= halt_at);
  assign i_data_reg = reg_q;
  assign i_data_mem = mem_q;

  always @(posedge clock) begin
    if (!i_reset && o_enable_pipe) begin
      pipe_pc  <= pipe_pc + 10'd1;
      pipe_cnt <= pipe_cnt + 1;
    end
    if (o_br_enable) reg_q <= reg_val(32'(o_br_addr));
    if (o_dm_enable) mem_q <= mem_val(32'(o_dm_addr));
  end

  logic [7:0]  exp_tx[$];
  logic [41:0] exp_wr[$];
  int unsigned tx_count   = 0;
  int unsigned wr_count   = 0;
  int unsigned en_samples = 0;
  int unsigned done_cnt   = 0;
  logic        outstanding = 1'b0;

  // Monitor and UART tx responder, sampled mid-cycle.
  always @(negedge clock) begin
    if (i_reset) begin
      outstanding = 1'b0;
      done_cnt    = 0;
      i_tx_done   = 1'b0;
    end else begin
      i_tx_done = 1'b0;
      if (done_cnt != 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          i_tx_done   = 1'b1;
          outstanding = 1'b0;
        end
      end
      if (o_enable_pipe) en_samples++;
      if (o_tx_start) begin
        tx_count++;
        check("tx_overlap", 32'(outstanding), 32'd0);
        check("tx_queue", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) check("tx_byte", 32'(o_tx_data), 32'(exp_tx.pop_front()));
        outstanding = 1'b1;
        done_cnt    = 3;
      end
      if (o_im_enable_write) begin
        logic [41:0] e;
        wr_count++;
        check("wr_queue", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(o_im_addr), 32'(e[41:32]));
          check("wr_data", o_im_data, e[31:0]);
        end
      end
    end
  end

  logic [9:0] m_addr = '0;
  logic       m_full = 1'b0;

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge clock); #1;
    i_rx_done = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    if (!m_full) exp_wr.push_back({m_addr, w});
    if (w == HALT) begin
      m_addr = '0;
      m_full = 1'b0;
    end else if (!m_full) begin
      if (m_addr == 10'h3FF) m_full = 1'b1;
      else m_addr = m_addr + 10'd1;
    end
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_tx.push_back(w[31-8*b -: 8]);
  endtask

  task automatic push_dump(input logic [9:0] pc);
    push_word({22'd0, pc});
    for (int unsigned r = 0; r < 32; r++) push_word(reg_val(r));
    for (int unsigned m = 0; m < 16; m++) push_word(mem_val(m));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (o_busy && c < 5000) begin
      @(posedge clock); #1;
      c++;
    end
    check(tag, 32'(o_busy), 32'd0);
  endtask

  task automatic wait_tx(input string tag, input int unsigned target);
    int c = 0;
    while (tx_count < target && c < 5000) begin
      @(posedge clock);
      c++;
    end
    check(tag, 32'(tx_count >= target), 32'd1);
  endtask

  initial begin
    int unsigned en0, tx0, wr0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_tx_start", 32'(o_tx_start), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_enable_pipe", 32'(o_enable_pipe), 32'd0);
    check("rst_im_we", 32'(o_im_enable_write), 32'd0);
    check("rst_debug_unit", 32'(o_debug_unit), 32'd0);
    check("rst_misc", 32'({o_en_read, o_br_enable, o_dm_enable, o_dm_enable_addr, o_tx_data, o_im_addr}), 32'd0);
    i_reset = 1'b0;

    // Basic load
    wr0 = wr_count;
    send_byte(8'h4C);
    check("load_debug_unit", 32'(o_debug_unit), 32'd1);
    check("load_busy", 32'(o_busy), 32'd1);
    load_word(32'h2001_0005);
    load_word(HALT);
    idle_cycles(2);
    check("load1_pending", 32'(exp_wr.size()), 32'd0);
    check("load1_wr_count", wr_count - wr0, 32'd2);
    check("load1_debug_unit", 32'(o_debug_unit), 32'd0);
    check("load1_busy", 32'(o_busy), 32'd0);

    // Program load then free run until halt
    send_byte(8'h4C);
    load_word(32'h2001_0005);
    load_word(32'h2002_0003);
    load_word(32'h0022_1820);
    load_word(HALT);
    idle_cycles(2);
    check("load2_pending", 32'(exp_wr.size()), 32'd0);
    en0 = en_samples; tx0 = tx_count;
    push_dump(pipe_pc + 10'd8);
    halt_at = pipe_cnt + 8; halt_arm = 1'b1;
    send_byte(8'h43);
    wait_idle("run_done");
    check("run_enable_cycles", en_samples - en0, 32'd8);
    check("run_tx_count", tx_count - tx0, 32'd196);
    check("run_pending", 32'(exp_tx.size()), 32'd0);

    // Command arriving mid-dump is dropped
    en0 = en_samples; tx0 = tx_count;
    push_dump(pipe_pc + 10'd5);
    halt_at = pipe_cnt + 5;
    send_byte(8'h43);
    wait_tx("drop_wait", tx0 + 10);
    send_byte(8'h43);
    wait_idle("drop_done");
    idle_cycles(5);
    check("drop_enable_cycles", en_samples - en0, 32'd5);
    check("drop_tx_count", tx_count - tx0, 32'd196);
    check("drop_busy", 32'(o_busy), 32'd0);
    halt_arm = 1'b0;

    // Single stepping
    send_byte(8'h53);
    check("step_idle_busy", 32'(o_busy), 32'd0);
    for (int s = 0; s < 2; s++) begin
      en0 = en_samples; tx0 = tx_count;
      push_dump(pipe_pc + 10'd1);
      send_byte(8'h4E);
      wait_idle("step_done");
      idle_cycles(3);
      check("step_enable_cycles", en_samples - en0, 32'd1);
      check("step_tx_count", tx_count - tx0, 32'd196);
      check("step_between_busy", 32'(o_busy), 32'd0);
    end
    send_byte(8'h45);
    en0 = en_samples; tx0 = tx_count;
    send_byte(8'h4E);
    idle_cycles(10);
    check("exit_step_enable", en_samples - en0, 32'd0);
    check("exit_step_tx", tx_count - tx0, 32'd0);

    // Reset in the middle of a dump
    tx0 = tx_count;
    push_dump(pipe_pc + 10'd2);
    halt_at = pipe_cnt + 2; halt_arm = 1'b1;
    send_byte(8'h43);
    wait_tx("rst_dump_wait", tx0 + 50);
    #1;
    i_reset = 1'b1;
    exp_tx.delete();
    @(posedge clock); #1;
    i_reset = 1'b0;
    halt_arm = 1'b0;
    check("rst_dump_busy", 32'(o_busy), 32'd0);
    idle_cycles(30);
    check("rst_dump_tx_count", tx_count - tx0, 32'd50);
    wr0 = wr_count;
    send_byte(8'h4C);
    load_word(32'h1234_5678);
    load_word(HALT);
    idle_cycles(2);
    check("rst_reload_pending", 32'(exp_wr.size()), 32'd0);
    check("rst_reload_wr_count", wr_count - wr0, 32'd2);

    // Address saturation
    wr0 = wr_count;
    send_byte(8'h4C);
    for (int i = 0; i < 1026; i++) load_word(32'h0100_0000 + 32'(i));
    load_word(HALT);
    idle_cycles(2);
    check("sat_wr_count", wr_count - wr0, 32'd1024);
    check("sat_pending", 32'(exp_wr.size()), 32'd0);
    check("sat_busy", 32'(o_busy), 32'd0);
    wr0 = wr_count;
    send_byte(8'h4C);
    load_word(32'hABCD_0001);
    load_word(HALT);
    idle_cycles(2);
    check("sat_reload_wr_count", wr_count - wr0, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/debug_controller.md
Name: debug_controller

Overview:
Debug controller that sequences the five-stage MIPS pipeline from a UART byte link.
- Loads the program into instruction memory.
- Runs the pipeline continuously or one clock at a time.
- After halt or after each step, dumps PC, all 32 registers and a data-memory window back over UART.
- Sits between the UART rx/tx byte interface and the pipeline debug/enable inputs.

Parameters:
NB_DATA, 32, width of instruction, register and memory words
NB_ADDR, 10, instruction/data memory address width (word addresses)
NB_REG, 5, register-file address width
N_REGISTER, 32, registers dumped
N_MEM_WORDS, 16, data-memory words dumped, addresses 0..N_MEM_WORDS-1
N_BYTES, 4, bytes per word on UART
HALT_INSTR, 32'hFFFFFFFF, halt opcode; terminates program load

Ports:
clock  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_rx_data  in  8  received UART byte
i_rx_done  in  1  one-cycle pulse, i_rx_data valid
i_tx_done  in  1  one-cycle pulse, previous tx byte finished
o_tx_data  out  8  byte to transmit, held until i_tx_done
o_tx_start  out  1  one-cycle pulse starting a transmission
i_pc  in  NB_ADDR  pipeline IF/ID PC
i_data_reg  in  NB_DATA  register-file debug read data
i_data_mem  in  NB_DATA  data-memory debug read data
i_halt  in  1  halt has reached WB
o_im_data  out  NB_DATA  instruction word to write
o_im_addr  out  NB_ADDR  instruction memory write address
o_im_enable_write  out  1  instruction memory write strobe
o_en_read  out  1  instruction memory read enable (high in RUN/STEP_EXEC)
o_debug_unit  out  1  high while loading; pipeline fetch uses debug path
o_enable_pipe  out  1  pipeline clock enable
o_br_addr  out  NB_REG  register debug read address
o_br_enable  out  1  register debug read enable
o_dm_addr  out  NB_ADDR  data-memory debug address
o_dm_enable  out  1  data-memory debug read enable
o_dm_enable_addr  out  1  selects o_dm_addr over pipeline address
o_busy  out  1  high in any state except IDLE and STEP_IDLE

Behaviour:
- Reset, synchronous: all outputs 0, state IDLE, counters and shift registers 0. Reset mid-load, run or dump aborts at the next edge; no further writes or tx pulses.
- Commands are accepted only in IDLE or STEP_IDLE. Bytes received in any other state are dropped.
  - 'L' (0x4C): enter LOAD.
  - 'C' (0x43): enter RUN.
  - 'S' (0x53): enter STEP_IDLE.
  - Unknown bytes are ignored.
- LOAD, word assembly:
  - Bytes are shifted in MSB first; the 4th byte completes a word.
  - The cycle after completion: o_im_enable_write=1 for exactly one cycle, o_im_data=word, o_im_addr=current address. The address then increments.
  - o_debug_unit=1 throughout LOAD.
- LOAD, end conditions:
  - A completed word equal to HALT_INSTR is written, then state goes to IDLE and the address resets to 0.
  - Address saturates at 2^NB_ADDR-1. Once that location is written, further words are discarded with no write strobe until HALT_INSTR arrives.
- RUN:
  - o_enable_pipe=1 and o_en_read=1 every cycle while i_halt=0.
  - The first cycle i_halt=1 is seen, o_enable_pipe drops in that same cycle (combinational on i_halt), then state goes to DUMP.
- STEP_IDLE:
  - 'N' (0x4E) gives STEP_EXEC for exactly one cycle (o_enable_pipe=1), then DUMP.
  - 'E' (0x45) returns to IDLE.
- DUMP: words are sent in order PC (zero-extended), R0..R31, M[0..N_MEM_WORDS-1]. Total 4*(1+N_REGISTER+N_MEM_WORDS) bytes (196 at defaults).
  - Per word: DUMP_ADDR drives o_br_addr or o_dm_addr with its enable. For memory words, o_dm_enable_addr is also driven.
  - DUMP_LATCH follows one cycle later and captures the word; read latency is one cycle.
  - DUMP_SEND pulses o_tx_start with the MSB byte.
  - DUMP_WAIT waits for i_tx_done. Repeat for 4 bytes.
  - o_tx_start never pulses while a byte is outstanding.
- After DUMP:
  - If in step mode and i_halt=0: STEP_IDLE.
  - Otherwise (RUN, or a step that reached halt): IDLE.
- o_enable_pipe is 0 in all states except RUN and STEP_EXEC.
- i_tx_done outside DUMP_WAIT is ignored.

Test Plan:
- Reset then 'L' + bytes 20 01 00 05, FF FF FF FF -> write strobe at addr 0 data 32'h20010005, then at addr 1 data 32'hFFFFFFFF; state IDLE; o_debug_unit low afterwards.
- Load 3-instruction program, 'C', pipeline raises i_halt after 8 cycles -> o_enable_pipe high 8 cycles then low; 196 tx_start pulses. First 4 bytes = PC MSB first; bytes 5-8 = R0 = 00 00 00 00.
- 'S', 'N' twice -> o_enable_pipe high exactly 1 cycle per 'N'; 196 bytes per step; o_busy low between steps; 'E' -> IDLE.
- Command byte 'C' arrives during DUMP -> dropped; no extra enable cycles; dump completes unchanged.
- i_reset asserted mid-dump at byte 50 -> o_tx_start low from next edge, state IDLE. A following 'L' load works from addr 0.
- Load 2^NB_ADDR+2 non-halt words then HALT_INSTR -> last write at addr 1023; the two overflow words and HALT_INSTR produce no strobe.
